// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART load scheduler.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_PICK, S_ADDR, S_BREQ, S_XFER, S_REL, S_FIN
    } state_e;

    localparam int NUM_SEG = 5;

    // Segment indices: bit position in seg_mask / pend.
    localparam logic [2:0] SEG_KERNEL = 3'd0;
    localparam logic [2:0] SEG_WEIGHT = 3'd1;
    localparam logic [2:0] SEG_BIAS   = 3'd2;
    localparam logic [2:0] SEG_IMAGE  = 3'd3;
    localparam logic [2:0] SEG_RESULT = 3'd4;

    // Codes the UART unit expects on UnUc_wr_sel.
    localparam logic [2:0] WR_SEL_KERNEL = 3'd0;
    localparam logic [2:0] WR_SEL_WEIGHT = 3'd1;
    localparam logic [2:0] WR_SEL_BIAS   = 3'd2;
    localparam logic [2:0] WR_SEL_IMAGE  = 3'd3;
    localparam logic [2:0] WR_SEL_RESULT = 3'd4;

    function automatic logic [2:0] wr_sel_code(input logic [2:0] seg);
        case (seg)
            SEG_WEIGHT: return WR_SEL_WEIGHT;
            SEG_BIAS:   return WR_SEL_BIAS;
            SEG_IMAGE:  return WR_SEL_IMAGE;
            SEG_RESULT: return WR_SEL_RESULT;
            default:    return WR_SEL_KERNEL;
        endcase
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [NUM_SEG-1:0] p);
        logic [2:0] r;
        r = '0;
        for (int i = NUM_SEG - 1; i >= 0; i--) begin
            if (p[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_sched_tmo.sv
// Per-segment transfer timeout counter with terminal-count flag.
module uart_sched_tmo
    import uart_sched_pkg::*;
#(
    parameter int              TMO_W   = 24,
    parameter logic [TMO_W-1:0] TMO_MAX = 24'hFF_FFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // Terminal count one short of TMO_MAX so that exactly TMO_MAX XFER cycles elapse.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tc = en && (cnt_q == TMO_LAST);

endmodule

// File: rtl/uart_load_sched.sv
// Sequences UART segment loads: picks each requested segment in index order,
// loads its start address, arbitrates for the bus and waits for completion or timeout.
module uart_load_sched
    import uart_sched_pkg::*;
#(
    parameter int               TMO_W       = 24,
    parameter logic [TMO_W-1:0] TMO_MAX     = 24'hFF_FFFF,
    parameter logic [27:0]      KERNEL_BASE = 28'h000_0000,
    parameter logic [27:0]      WEIGHT_BASE = 28'h010_0000,
    parameter logic [27:0]      BIAS_BASE   = 28'h020_0000,
    parameter logic [27:0]      IMAGE_BASE  = 28'h030_0000,
    parameter logic [27:0]      RESULT_BASE = 28'h040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  seg_mask,
    input  logic        abort,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        uart_en,
    output logic [2:0]  UnUc_wr_sel,
    output logic        link_write,
    output logic        link_read,
    output logic [27:0] UnUb_initAddr,
    output logic        UnUb_initAddrEn,
    input  logic        wdone,
    input  logic        rdone,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_seg
);

    state_e      state_q, state_d;
    logic [4:0]  pend_q, pend_d;
    logic [2:0]  cur_seg_q, cur_seg_d;
    logic        err_q, err_d;
    logic [2:0]  err_seg_q, err_seg_d;

    logic        is_result, seg_done, tmo_tc, in_seg;
    logic [27:0] seg_base;

    assign is_result = (cur_seg_q == SEG_RESULT);
    // Only the done input matching the transfer direction counts.
    assign seg_done  = is_result ? rdone : wdone;

    uart_sched_tmo #(.TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (state_q == S_BREQ && bus_gnt),
        .en  (state_q == S_XFER),
        .tc  (tmo_tc)
    );

    // Base address of the segment being processed.
    always_comb begin
        case (cur_seg_q)
            SEG_WEIGHT: seg_base = WEIGHT_BASE;
            SEG_BIAS:   seg_base = BIAS_BASE;
            SEG_IMAGE:  seg_base = IMAGE_BASE;
            SEG_RESULT: seg_base = RESULT_BASE;
            default:    seg_base = KERNEL_BASE;
        endcase
    end

    // Next-state, pending-mask and error bookkeeping; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        cur_seg_d = cur_seg_q;
        err_d     = err_q;
        err_seg_d = err_seg_q;
        case (state_q)
            S_IDLE: if (start && seg_mask != '0) begin
                pend_d    = seg_mask;
                err_d     = 1'b0;
                err_seg_d = '0;
                state_d   = S_PICK;
            end
            S_PICK: if (pend_q == '0) begin
                state_d = S_FIN;
            end else begin
                cur_seg_d = lowest_set(pend_q);
                state_d   = S_ADDR;
            end
            S_ADDR: state_d = S_BREQ;
            S_BREQ: if (bus_gnt) state_d = S_XFER;
            S_XFER: if (seg_done) begin
                // Completion beats a coincident timeout.
                pend_d[cur_seg_q] = 1'b0;
                state_d           = S_REL;
            end else if (tmo_tc) begin
                err_d     = 1'b1;
                err_seg_d = cur_seg_q;
                pend_d    = '0;
                state_d   = S_REL;
            end
            S_REL:   state_d = S_PICK;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            pend_d    = '0;
            err_d     = err_q;
            err_seg_d = err_seg_q;
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            cur_seg_q <= '0;
            err_q     <= 1'b0;
            err_seg_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            cur_seg_q <= cur_seg_d;
            err_q     <= err_d;
            err_seg_q <= err_seg_d;
        end
    end

    // Outputs decoded from state so abort and reset silence them at once.
    always_comb begin
        in_seg          = (state_q == S_ADDR) || (state_q == S_BREQ) ||
                          (state_q == S_XFER) || (state_q == S_REL);
        uart_en         = in_seg;
        UnUc_wr_sel     = in_seg ? wr_sel_code(cur_seg_q) : '0;
        UnUb_initAddrEn = (state_q == S_ADDR);
        UnUb_initAddr   = (state_q == S_ADDR) ? seg_base : '0;
        bus_req         = (state_q == S_BREQ) || (state_q == S_XFER);
        link_write      = (state_q == S_XFER) && bus_gnt && !is_result;
        link_read       = (state_q == S_XFER) && bus_gnt && is_result;
        busy            = (state_q != S_IDLE);
        done            = (state_q == S_FIN);
        err             = err_q;
        err_seg         = err_seg_q;
    end

endmodule
